// File: rtl/control_itf.sv
// Shared pipeline control types: forwarding select encoding, memory-stall FSM
// states and the per-cycle control word driven into the datapath.
package control_itf;

  // Operand source for the EX-stage ALU inputs; 2'b11 is reserved.
  typedef enum logic [1:0] {
    REGFILE = 2'b00,
    EXMEM   = 2'b01,
    MEMWB   = 2'b10
  } fwd_sel_t;

  // WAIT_I: data side done, fetch pending. WAIT_D: fetch done, data pending.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    WAIT_BOTH = 2'b01,
    WAIT_I    = 2'b10,
    WAIT_D    = 2'b11
  } mem_state_t;

  typedef struct packed {
    logic     pipe_load_ifid;
    logic     pipe_load_idex;
    logic     pipe_load_exmem;
    logic     pipe_load_memwb;
    logic     pipe_rst_ifid;
    logic     pipe_rst_idex;
    logic     pipe_rst_exmem;
    logic     pipe_rst_memwb;
    fwd_sel_t rs1mux_sel;
    fwd_sel_t rs2mux_sel;
  } control;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select for one EX-stage source operand. EX/MEM wins over MEM/WB
// because it holds the younger value; x0 is never forwarded.
module forward_unit
  import control_itf::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_load_regfile,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_load_regfile,
  output fwd_sel_t              sel
);

  // Priority match against the two in-flight destinations.
  always_comb begin
    sel = REGFILE;
    if (rs != '0) begin
      if (exmem_load_regfile && (exmem_rd == rs)) begin
        sel = EXMEM;
      end else if (memwb_load_regfile && (memwb_rd == rs)) begin
        sel = MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: cache-miss freeze,
// load-use bubble, taken-branch flush and operand forwarding selects.
// Build option: define FORWARDING_EN to enable forwarding; otherwise selects
// are tied to the register file and any RAW dependency holds ID.
module pipeline_hazard_ctrl
  import control_itf::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rs1,
  input  logic [REG_ADDR_W-1:0] idex_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_load_regfile,
  input  logic                  idex_dcache_read,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_load_regfile,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_load_regfile,
  input  logic                  br_taken,
  input  logic                  icache_read,
  input  logic                  icache_resp,
  input  logic                  dcache_req,
  input  logic                  dcache_resp,
  output logic                  pc_load,
  output control                ctrl
);

  mem_state_t r_state;
  mem_state_t w_state_next;
  logic       w_mem_stall;
  logic       w_miss_i;
  logic       w_miss_d;
  logic       w_hold_id;
  fwd_sel_t   w_rs1_sel;
  fwd_sel_t   w_rs2_sel;

  assign w_miss_i = icache_read & ~icache_resp;
  assign w_miss_d = dcache_req & ~dcache_resp;

`ifdef FORWARDING_EN
  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs                 (idex_rs1),
    .exmem_rd           (exmem_rd),
    .exmem_load_regfile (exmem_load_regfile),
    .memwb_rd           (memwb_rd),
    .memwb_load_regfile (memwb_load_regfile),
    .sel                (w_rs1_sel)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs                 (idex_rs2),
    .exmem_rd           (exmem_rd),
    .exmem_load_regfile (exmem_load_regfile),
    .memwb_rd           (memwb_rd),
    .memwb_load_regfile (memwb_load_regfile),
    .sel                (w_rs2_sel)
  );

  // Only a load result is too late to forward into the next instruction.
  assign w_hold_id = idex_dcache_read && idex_load_regfile && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
`else
  logic w_unused_fwd;
  logic w_raw_rs1;
  logic w_raw_rs2;

  assign w_rs1_sel    = REGFILE;
  assign w_rs2_sel    = REGFILE;
  assign w_unused_fwd = ^{idex_rs1, idex_rs2, idex_dcache_read};

  // Without bypass paths, ID waits until no older instruction still owes the register.
  assign w_raw_rs1 = (ifid_rs1 != '0) &&
                     ((idex_load_regfile  && (idex_rd  == ifid_rs1)) ||
                      (exmem_load_regfile && (exmem_rd == ifid_rs1)) ||
                      (memwb_load_regfile && (memwb_rd == ifid_rs1)));
  assign w_raw_rs2 = (ifid_rs2 != '0) &&
                     ((idex_load_regfile  && (idex_rd  == ifid_rs2)) ||
                      (exmem_load_regfile && (exmem_rd == ifid_rs2)) ||
                      (memwb_load_regfile && (memwb_rd == ifid_rs2)));
  assign w_hold_id = w_raw_rs1 | w_raw_rs2;
`endif

  // Memory FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pending-response tracking; a response is absorbed the cycle it arrives.
  always_comb begin
    w_state_next = r_state;
    w_mem_stall  = 1'b0;
    unique case (r_state)
      RUN: begin
        w_mem_stall = w_miss_i | w_miss_d;
        if (w_miss_i && w_miss_d) begin
          w_state_next = WAIT_BOTH;
        end else if (w_miss_i) begin
          w_state_next = WAIT_I;
        end else if (w_miss_d) begin
          w_state_next = WAIT_D;
        end
      end
      WAIT_BOTH: begin
        w_mem_stall = ~(icache_resp & dcache_resp);
        if (icache_resp && dcache_resp) begin
          w_state_next = RUN;
        end else if (icache_resp) begin
          w_state_next = WAIT_D;
        end else if (dcache_resp) begin
          w_state_next = WAIT_I;
        end
      end
      WAIT_I: begin
        w_mem_stall = ~icache_resp;
        if (icache_resp) w_state_next = RUN;
      end
      WAIT_D: begin
        w_mem_stall = ~dcache_resp;
        if (dcache_resp) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  // Control word: rst > mem stall > flush > ID hold > normal advance.
  always_comb begin
    pc_load              = 1'b1;
    ctrl.pipe_load_ifid  = 1'b1;
    ctrl.pipe_load_idex  = 1'b1;
    ctrl.pipe_load_exmem = 1'b1;
    ctrl.pipe_load_memwb = 1'b1;
    ctrl.pipe_rst_ifid   = 1'b0;
    ctrl.pipe_rst_idex   = 1'b0;
    ctrl.pipe_rst_exmem  = 1'b0;
    ctrl.pipe_rst_memwb  = 1'b0;
    ctrl.rs1mux_sel      = w_rs1_sel;
    ctrl.rs2mux_sel      = w_rs2_sel;
    if (rst) begin
      pc_load              = 1'b0;
      ctrl.pipe_load_ifid  = 1'b0;
      ctrl.pipe_load_idex  = 1'b0;
      ctrl.pipe_load_exmem = 1'b0;
      ctrl.pipe_load_memwb = 1'b0;
      ctrl.pipe_rst_ifid   = 1'b1;
      ctrl.pipe_rst_idex   = 1'b1;
      ctrl.pipe_rst_exmem  = 1'b1;
      ctrl.pipe_rst_memwb  = 1'b1;
      ctrl.rs1mux_sel      = REGFILE;
      ctrl.rs2mux_sel      = REGFILE;
    end else if (w_mem_stall) begin
      pc_load              = 1'b0;
      ctrl.pipe_load_ifid  = 1'b0;
      ctrl.pipe_load_idex  = 1'b0;
      ctrl.pipe_load_exmem = 1'b0;
      ctrl.pipe_load_memwb = 1'b0;
    end else if (br_taken) begin
      ctrl.pipe_rst_ifid = 1'b1;
      ctrl.pipe_rst_idex = 1'b1;
    end else if (w_hold_id) begin
      // Keep PC and IF/ID, inject a bubble into EX.
      pc_load             = 1'b0;
      ctrl.pipe_load_ifid = 1'b0;
      ctrl.pipe_rst_idex  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the
// combinational hazard/forwarding decode, plus hand sequences for cache
// misses, reset mid-miss and multi-cycle dependency stalls.
module tb_pipeline_hazard_ctrl;
  import control_itf::*;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Observed word: {pc_load, load ifid/idex/exmem/memwb, rst ifid/idex/exmem/memwb, rs1, rs2}
  localparam logic [12:0] NORM  = 13'b1_1111_0000_00_00;
  localparam logic [12:0] STALL = 13'b0_0000_0000_00_00;
  localparam logic [12:0] BUB   = 13'b0_0111_0100_00_00;
  localparam logic [12:0] FLUSH = 13'b1_1111_1100_00_00;
  localparam logic [12:0] RSTW  = 13'b0_0000_1111_00_00;

  logic       clk;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_load_regfile, idex_dcache_read, exmem_load_regfile, memwb_load_regfile;
  logic       br_taken, icache_read, icache_resp, dcache_req, dcache_resp;
  logic       pc_load;
  control     ctrl;
  logic [12:0] obs;

  int n_total = 0;
  int n_pass  = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .ifid_rs1           (ifid_rs1),
    .ifid_rs2           (ifid_rs2),
    .idex_rs1           (idex_rs1),
    .idex_rs2           (idex_rs2),
    .idex_rd            (idex_rd),
    .idex_load_regfile  (idex_load_regfile),
    .idex_dcache_read   (idex_dcache_read),
    .exmem_rd           (exmem_rd),
    .exmem_load_regfile (exmem_load_regfile),
    .memwb_rd           (memwb_rd),
    .memwb_load_regfile (memwb_load_regfile),
    .br_taken           (br_taken),
    .icache_read        (icache_read),
    .icache_resp        (icache_resp),
    .dcache_req         (dcache_req),
    .dcache_resp        (dcache_resp),
    .pc_load            (pc_load),
    .ctrl               (ctrl)
  );

  assign obs = {pc_load, ctrl.pipe_load_ifid, ctrl.pipe_load_idex, ctrl.pipe_load_exmem,
                ctrl.pipe_load_memwb, ctrl.pipe_rst_ifid, ctrl.pipe_rst_idex,
                ctrl.pipe_rst_exmem, ctrl.pipe_rst_memwb, ctrl.rs1mux_sel, ctrl.rs2mux_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  i_rs1, i_rs2, e_rs1, e_rs2, e_rd;
    logic        e_ld, e_dr;
    logic [4:0]  m_rd;
    logic        m_ld;
    logic [4:0]  w_rd;
    logic        w_ld;
    logic        br;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] with_sel(logic [12:0] b, logic [1:0] s1, logic [1:0] s2);
    return {b[12:4], s1, s2};
  endfunction

  task automatic clear_regs();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
    idex_load_regfile = 1'b0; idex_dcache_read = 1'b0;
    exmem_rd = '0; exmem_load_regfile = 1'b0;
    memwb_rd = '0; memwb_load_regfile = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic clear_mem();
    icache_read = 1'b0; icache_resp = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ifid_rs1 = v.i_rs1; ifid_rs2 = v.i_rs2; idex_rs1 = v.e_rs1; idex_rs2 = v.e_rs2;
    idex_rd = v.e_rd; idex_load_regfile = v.e_ld; idex_dcache_read = v.e_dr;
    exmem_rd = v.m_rd; exmem_load_regfile = v.m_ld;
    memwb_rd = v.w_rd; memwb_load_regfile = v.w_ld;
    br_taken = v.br;
  endtask

  task automatic chk(input string nm, input logic [12:0] exp);
    #1;
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %b want %b", nm, obs, exp);
    else n_pass++;
  endtask

  task automatic chk_state(input string nm, input mem_state_t exp);
    n_total++;
    if (dut.r_state !== exp) $display("FAIL %s: state got %0d want %0d", nm, dut.r_state, exp);
    else n_pass++;
  endtask

  initial begin
    // name, ifid rs1/rs2, idex rs1/rs2/rd, idex ld/dread, exmem rd/ld, memwb rd/ld, br, expected
    vecs.push_back('{"idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM});
    vecs.push_back('{"fwd_exmem_rs1", 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0,
                     FWD ? with_sel(NORM, 2'b01, 2'b00) : NORM});
    vecs.push_back('{"fwd_memwb_rs1", 0, 0, 5, 0, 0, 0, 0, 0, 0, 5, 1, 0,
                     FWD ? with_sel(NORM, 2'b10, 2'b00) : NORM});
    vecs.push_back('{"fwd_prio_rs2", 0, 0, 1, 6, 0, 0, 0, 6, 1, 6, 1, 0,
                     FWD ? with_sel(NORM, 2'b00, 2'b01) : NORM});
    vecs.push_back('{"fwd_x0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, NORM});
    vecs.push_back('{"fwd_we_off", 0, 0, 5, 9, 0, 0, 0, 5, 0, 9, 1, 0,
                     FWD ? with_sel(NORM, 2'b00, 2'b10) : NORM});
    vecs.push_back('{"loaduse_rs1", 7, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, BUB});
    vecs.push_back('{"loaduse_rs2", 2, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, BUB});
    vecs.push_back('{"loaduse_x0", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, NORM});
    vecs.push_back('{"loaduse_other", 6, 2, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, NORM});
    vecs.push_back('{"alu_dep_ex", 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, FWD ? NORM : BUB});
    vecs.push_back('{"dep_wb", 0, 4, 4, 0, 0, 0, 0, 0, 0, 4, 1, 0,
                     FWD ? with_sel(NORM, 2'b10, 2'b00) : BUB});
    vecs.push_back('{"dep_mem_we_off", 8, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, NORM});
    vecs.push_back('{"br_loaduse", 7, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, FLUSH});
    vecs.push_back('{"br_alone", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLUSH});

    clear_regs();
    clear_mem();
    rst = 1'b1;

    // Reset output, with a forwarding match and a fetch pending
    @(negedge clk);
    idex_rs1 = 5; exmem_rd = 5; exmem_load_regfile = 1'b1; icache_read = 1'b1;
    chk("reset_outputs", RSTW);
    @(negedge clk);
    rst = 1'b0;
    clear_regs();
    clear_mem();
    chk_state("reset_state", RUN);
    chk("post_reset_norm", NORM);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      chk(vecs[i].name, vecs[i].exp);
    end
    @(negedge clk);
    clear_regs();

`ifdef FORWARDING_EN
    // lw x7 in EX, add x8,x7,x1 in ID: one bubble, then MEM/WB forward
    @(negedge clk);
    ifid_rs1 = 7; ifid_rs2 = 1; idex_rs1 = 2; idex_rd = 7;
    idex_load_regfile = 1'b1; idex_dcache_read = 1'b1;
    chk("lu_bubble", BUB);
    @(negedge clk);
    idex_rs1 = 0; idex_rd = 0; idex_load_regfile = 1'b0; idex_dcache_read = 1'b0;
    exmem_rd = 7; exmem_load_regfile = 1'b1;
    chk("lu_after_bubble", NORM);
    @(negedge clk);
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 7; idex_rs2 = 1; idex_rd = 8;
    idex_load_regfile = 1'b1; exmem_rd = 0; exmem_load_regfile = 1'b0;
    memwb_rd = 7; memwb_load_regfile = 1'b1;
    chk("lu_fwd_memwb", with_sel(NORM, 2'b10, 2'b00));
`else
    // add x3 in EX, dependent in ID: held until x3 leaves WB
    @(negedge clk);
    ifid_rs1 = 3; idex_rd = 3; idex_load_regfile = 1'b1;
    chk("raw_stall_ex", BUB);
    @(negedge clk);
    idex_rd = 0; idex_load_regfile = 1'b0; exmem_rd = 3; exmem_load_regfile = 1'b1;
    chk("raw_stall_mem", BUB);
    @(negedge clk);
    exmem_rd = 0; exmem_load_regfile = 1'b0; memwb_rd = 3; memwb_load_regfile = 1'b1;
    chk("raw_stall_wb", BUB);
    @(negedge clk);
    ifid_rs1 = 0; memwb_rd = 0; memwb_load_regfile = 1'b0;
    idex_rs1 = 3; idex_rd = 4; idex_load_regfile = 1'b1;
    chk("raw_release", NORM);
`endif
    @(negedge clk);
    clear_regs();

    // Split miss: fetch completes first, data completes four cycles later
    @(negedge clk);
    icache_read = 1'b1; dcache_req = 1'b1;
    chk("miss_c1", STALL);
    @(negedge clk);
    chk_state("miss_wait_both", WAIT_BOTH);
    chk("miss_c2", STALL);
    @(negedge clk);
    icache_resp = 1'b1;
    chk("miss_iresp", STALL);
    @(negedge clk);
    icache_resp = 1'b0; br_taken = 1'b1;
    chk_state("miss_wait_d", WAIT_D);
    chk("miss_br_suppressed", STALL);
    @(negedge clk);
    br_taken = 1'b0;
    chk("miss_c5", STALL);
    @(negedge clk);
    chk("miss_c6", STALL);
    @(negedge clk);
    dcache_resp = 1'b1; br_taken = 1'b1;
    chk("miss_release_br", FLUSH);
    @(negedge clk);
    clear_mem(); br_taken = 1'b0;
    chk_state("miss_run", RUN);
    chk("miss_after", NORM);

    // Early data response in WAIT_BOTH is remembered
    @(negedge clk);
    icache_read = 1'b1; dcache_req = 1'b1;
    chk("early_c1", STALL);
    @(negedge clk);
    dcache_resp = 1'b1;
    chk("early_dresp", STALL);
    @(negedge clk);
    dcache_resp = 1'b0;
    chk_state("early_wait_i", WAIT_I);
    chk("early_wait", STALL);
    @(negedge clk);
    icache_resp = 1'b1;
    chk("early_release", NORM);
    @(negedge clk);
    clear_mem();
    chk_state("early_run", RUN);

    // Same-cycle hits, then a data-only miss
    @(negedge clk);
    icache_read = 1'b1; icache_resp = 1'b1; dcache_req = 1'b1; dcache_resp = 1'b1;
    chk("hit_both", NORM);
    @(negedge clk);
    dcache_resp = 1'b0;
    chk_state("hit_run", RUN);
    chk("dmiss_only", STALL);
    @(negedge clk);
    icache_read = 1'b0; icache_resp = 1'b0;
    chk_state("dmiss_wait_d", WAIT_D);
    dcache_resp = 1'b1;
    chk("dmiss_release", NORM);

    // Reset mid-miss with a response arriving during reset
    @(negedge clk);
    clear_mem();
    icache_read = 1'b1; dcache_req = 1'b1;
    chk("rmiss_enter", STALL);
    @(negedge clk);
    chk_state("rmiss_wait_both", WAIT_BOTH);
    rst = 1'b1; dcache_resp = 1'b1;
    chk("rmiss_rst_out", RSTW);
    @(negedge clk);
    rst = 1'b0;
    clear_mem();
    dcache_resp = 1'b1;
    chk_state("rmiss_run", RUN);
    chk("rmiss_stale_resp", NORM);
    @(negedge clk);
    dcache_resp = 1'b0; dcache_req = 1'b1;
    chk_state("rmiss_stale_ignored", RUN);
    chk("rmiss_new_req", STALL);
    @(negedge clk);
    chk_state("rmiss_wait_d", WAIT_D);
    dcache_resp = 1'b1;
    chk("rmiss_release", NORM);
    @(negedge clk);
    clear_mem();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
